// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch sequencer.
//   fetch_state_t : sequencer state encoding (IDLE, REQ, HOLD, DRAIN)
//   DEFAULT_STEP  : default PC increment per sequential fetch
//   PERF_W        : width of the optional performance counters
//   PERF_MAX      : saturation value of the performance counters
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam int DEFAULT_STEP = 4;

  localparam int PERF_W = 16;
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

endpackage

// File: rtl/fetch_perf_cnt.sv
// ---------------------------------------------------------------------------
// fetch_perf_cnt
// Saturating event counter used for the optional fetch statistics.
// Ports:
//   clk      : clock, counter updates on the rising edge
//   rst      : synchronous active-high clear
//   i_inc    : count one event this cycle
//   o_count  : current count, sticks at PERF_MAX once reached
// ---------------------------------------------------------------------------
module fetch_perf_cnt
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inc,
  output logic [PERF_W-1:0] o_count
);

  logic [PERF_W-1:0] r_count;

  // Count events until the all-ones value, then hold so a long run never
  // wraps back to a misleadingly small number.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != PERF_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer: owns the PC, runs the instruction-memory
// request/acknowledge handshake, presents fetched words to decode with a
// valid/ready handshake and redirects on taken branches, discarding any
// response that is still in flight.
//
// Optional feature macro: FETCH_PERF_EN (adds o_perf_fetch / o_perf_flush).
//
// Ports:
//   clk           : clock, all state on the rising edge
//   rst           : synchronous active-high reset
//   o_imem_req    : fetch request to instruction memory
//   o_imem_addr   : fetch address (always equals o_pc_out)
//   i_imem_ack    : memory response valid
//   i_imem_rdata  : fetched instruction word
//   i_br_taken    : one-cycle redirect pulse
//   i_br_target   : redirect address, used as-is (no alignment check)
//   o_instr_valid : o_instr / o_instr_pc valid toward decode
//   i_instr_ready : decode accepts when valid and ready
//   o_instr       : registered instruction word
//   o_instr_pc    : address the instruction was fetched from
//   o_perf_fetch  : (FETCH_PERF_EN) instructions accepted by decode
//   o_perf_flush  : (FETCH_PERF_EN) branch redirects seen
//   o_pc_out      : current fetch PC
// ---------------------------------------------------------------------------
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               INSTR_W = 32,
  parameter int               STEP    = DEFAULT_STEP,
  parameter logic [WIDTH-1:0] RST_VEC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               o_imem_req,
  output logic [WIDTH-1:0]   o_imem_addr,
  input  logic               i_imem_ack,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  input  logic               i_br_taken,
  input  logic [WIDTH-1:0]   i_br_target,
  output logic               o_instr_valid,
  input  logic               i_instr_ready,
  output logic [INSTR_W-1:0] o_instr,
  output logic [WIDTH-1:0]   o_instr_pc,
`ifdef FETCH_PERF_EN
  output logic [PERF_W-1:0]  o_perf_fetch,
  output logic [PERF_W-1:0]  o_perf_flush,
`endif
  output logic [WIDTH-1:0]   o_pc_out
);

  fetch_state_t        r_state;
  logic [WIDTH-1:0]    r_pc;
  logic                r_imem_req;
  logic [WIDTH-1:0]    r_imem_addr;
  logic                r_valid;
  logic [INSTR_W-1:0]  r_instr;
  logic [WIDTH-1:0]    r_instr_pc;

  fetch_state_t        w_state;
  logic [WIDTH-1:0]    w_pc;
  logic                w_valid;
  logic [INSTR_W-1:0]  w_instr;
  logic [WIDTH-1:0]    w_instr_pc;

  // Next-state decode. A taken branch outranks every other event in the
  // same cycle. When the branch lands in REQ before the ack arrives, the
  // outstanding response still has to be absorbed, hence the DRAIN state;
  // if the ack arrives in the same cycle it is simply dropped and the new
  // target is requested straight away. An ack arriving in DRAIN together
  // with a further branch is still consumed so the sequencer cannot wait
  // forever for a response that has already come back.
  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_valid    = r_valid;
    w_instr    = r_instr;
    w_instr_pc = r_instr_pc;
    case (r_state)
      IDLE: begin
        if (i_br_taken) begin
          w_pc    = i_br_target;
          w_valid = 1'b0;
        end
        w_state = REQ;
      end
      REQ: begin
        if (i_br_taken) begin
          w_pc    = i_br_target;
          w_state = i_imem_ack ? REQ : DRAIN;
        end else if (i_imem_ack) begin
          w_instr    = i_imem_rdata;
          w_instr_pc = r_pc;
          w_pc       = r_pc + WIDTH'(STEP);
          w_valid    = 1'b1;
          w_state    = HOLD;
        end
      end
      HOLD: begin
        if (i_br_taken) begin
          w_pc    = i_br_target;
          w_valid = 1'b0;
          w_state = REQ;
        end else if (i_instr_ready) begin
          w_valid = 1'b0;
          w_state = REQ;
        end
      end
      DRAIN: begin
        if (i_br_taken) begin
          w_pc = i_br_target;
        end
        if (i_imem_ack) begin
          w_state = REQ;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // State and output registers. The request line and address are registered
  // from the next-state values so they line up with the state they belong
  // to, and the address tracks the PC in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pc        <= RST_VEC;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RST_VEC;
      r_valid     <= 1'b0;
      r_instr     <= '0;
      r_instr_pc  <= '0;
    end else begin
      r_state     <= w_state;
      r_pc        <= w_pc;
      r_imem_req  <= (w_state == REQ);
      r_imem_addr <= w_pc;
      r_valid     <= w_valid;
      r_instr     <= w_instr;
      r_instr_pc  <= w_instr_pc;
    end
  end

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_imem_addr;
  assign o_instr_valid = r_valid;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_pc_out      = r_pc;

`ifdef FETCH_PERF_EN
  // An instruction only counts as delivered when decode takes it in HOLD
  // and no branch in the same cycle throws it away.
  logic w_accept;
  assign w_accept = (r_state == HOLD) && i_instr_ready && !i_br_taken;

  fetch_perf_cnt u_perf_fetch (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_accept),
    .o_count (o_perf_fetch)
  );

  fetch_perf_cnt u_perf_flush (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (i_br_taken),
    .o_count (o_perf_flush)
  );
`endif

endmodule
